fm_special_detect: RTL and testbench

- Pipelined operand classifier for the floating-point multiplier; it produces the special-case flags (zero, aisnan, bisnan, infinity) that the multiplier's special-case resolution logic consumes.
- Accepts operand pairs A/B over a valid/ready handshake and classifies each operand.
- Adds per-operand signaling-NaN detection, sticky invalid-exception flags and a saturating special-case event counter, readable by the host.

---
 rtl/fm_special_detect.sv | 185 ++++++++++++++++++
 tb/tb_fm_special_detect.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_special_detect.sv
// Two-stage operand classifier for the FP multiplier. Stage 1 registers the
// incoming pair; stage 2 registers the pair together with its special-case
// flags. Sticky invalid flag and a saturating special-case counter are
// updated on each output transfer.
module fm_special_detect #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WEXP  = 8,
  parameter int unsigned WSIG  = 23,
  parameter int unsigned FTZ   = 1,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             zero,
  output logic             aisnan,
  output logic             bisnan,
  output logic             infinity,
  output logic             asnan_sig,
  output logic             bsnan_sig,
  output logic             specialcase,
  output logic             sticky_invalid,
  input  logic             flag_clear,
  output logic [CNTW-1:0]  special_cnt
);

  localparam logic            FtzEn  = (FTZ != 0);
  localparam logic [CNTW-1:0] CntMax = '1;

  // Returns {zero, inf, nan, snan} for one operand's exponent/significand.
  function automatic logic [3:0] classify(input logic [WEXP-1:0] e, input logic [WSIG-1:0] s);
    logic e_zero, e_ones, s_zero, is_nan;
    e_zero = (e == '0);
    e_ones = (e == '1);
    s_zero = (s == '0);
    is_nan = e_ones & ~s_zero;
    // A quiet NaN has the top significand bit set; clear means signaling.
    return {e_zero & (s_zero | FtzEn), e_ones & s_zero, is_nan, is_nan & ~s[WSIG-1]};
  endfunction

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_inf_q, s2_inf_d;
  logic             s2_anan_q, s2_anan_d;
  logic             s2_bnan_q, s2_bnan_d;
  logic             s2_asig_q, s2_asig_d;
  logic             s2_bsig_q, s2_bsig_d;

  // Host-visible status
  logic             sticky_q, sticky_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic s2_adv, s1_adv, in_xfer, out_xfer;
  logic [3:0] cls_a, cls_b;
  logic spec_s2, invalid_s2;

  // Handshake: a stage may advance when the stage after it is empty or draining.
  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_adv;
    in_ready = ~s1_valid_q | s2_adv;
    in_xfer  = in_valid & in_ready;
    out_xfer = s2_valid_q & out_ready;
  end

  // Stage 1 next state: load on input transfer, empty when it moves on alone.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: classify stage 1 contents as they advance.
  always_comb begin
    cls_a      = classify(s1_a_q[WSIG +: WEXP], s1_a_q[WSIG-1:0]);
    cls_b      = classify(s1_b_q[WSIG +: WEXP], s1_b_q[WSIG-1:0]);
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    s2_zero_d  = s2_zero_q;
    s2_inf_d   = s2_inf_q;
    s2_anan_d  = s2_anan_q;
    s2_bnan_d  = s2_bnan_q;
    s2_asig_d  = s2_asig_q;
    s2_bsig_d  = s2_bsig_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_a_d     = s1_a_q;
      s2_b_d     = s1_b_q;
      s2_zero_d  = cls_a[3] | cls_b[3];
      s2_inf_d   = cls_a[2] | cls_b[2];
      s2_anan_d  = cls_a[1];
      s2_bnan_d  = cls_b[1];
      s2_asig_d  = cls_a[0];
      s2_bsig_d  = cls_b[0];
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end
  end

  // Sticky flag and counter: a same-cycle set/increment beats flag_clear.
  always_comb begin
    spec_s2    = s2_zero_q | s2_anan_q | s2_bnan_q | s2_inf_q;
    invalid_s2 = (s2_inf_q & s2_zero_q) | s2_asig_q | s2_bsig_q;
    sticky_d   = (sticky_q & ~flag_clear) | (out_xfer & invalid_s2);
    cnt_d      = cnt_q;
    if (flag_clear) begin
      cnt_d = (out_xfer & spec_s2) ? CNTW'(1) : '0;
    end else if (out_xfer && spec_s2 && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_zero_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_anan_q  <= 1'b0;
      s2_bnan_q  <= 1'b0;
      s2_asig_q  <= 1'b0;
      s2_bsig_q  <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      s2_zero_q  <= s2_zero_d;
      s2_inf_q   <= s2_inf_d;
      s2_anan_q  <= s2_anan_d;
      s2_bnan_q  <= s2_bnan_d;
      s2_asig_q  <= s2_asig_d;
      s2_bsig_q  <= s2_bsig_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output mapping straight from stage 2 and status registers.
  always_comb begin
    out_valid      = s2_valid_q;
    a_out          = s2_a_q;
    b_out          = s2_b_q;
    zero           = s2_zero_q;
    aisnan         = s2_anan_q;
    bisnan         = s2_bnan_q;
    infinity       = s2_inf_q;
    asnan_sig      = s2_asig_q;
    bsnan_sig      = s2_bsig_q;
    specialcase    = spec_s2;
    sticky_invalid = sticky_q;
    special_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_fm_special_detect.sv
// Bench for fm_special_detect: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_fm_special_detect;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, flag_clear;
  logic [31:0] a, b;

  logic        in_ready, out_valid, zero, aisnan, bisnan, infinity;
  logic        asnan_sig, bsnan_sig, specialcase, sticky_invalid;
  logic [31:0] a_out, b_out;
  logic [3:0]  special_cnt;

  logic        n_in_ready, n_out_valid, n_zero, n_aisnan, n_bisnan, n_infinity;
  logic        n_asnan_sig, n_bsnan_sig, n_specialcase, n_sticky_invalid;
  logic [31:0] n_a_out, n_b_out;
  logic [15:0] n_special_cnt;

  always #5 clk = ~clk;

  fm_special_detect #(.WIDTH(32), .WEXP(8), .WSIG(23), .FTZ(1), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .b_out(b_out),
    .zero(zero), .aisnan(aisnan), .bisnan(bisnan), .infinity(infinity),
    .asnan_sig(asnan_sig), .bsnan_sig(bsnan_sig), .specialcase(specialcase),
    .sticky_invalid(sticky_invalid), .flag_clear(flag_clear), .special_cnt(special_cnt)
  );

  // Second build with denormals kept as finite nonzero values.
  fm_special_detect #(.WIDTH(32), .WEXP(8), .WSIG(23), .FTZ(0), .CNTW(16)) dut_noftz (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .a(a), .b(b),
    .out_valid(n_out_valid), .out_ready(out_ready), .a_out(n_a_out), .b_out(n_b_out),
    .zero(n_zero), .aisnan(n_aisnan), .bisnan(n_bisnan), .infinity(n_infinity),
    .asnan_sig(n_asnan_sig), .bsnan_sig(n_bsnan_sig), .specialcase(n_specialcase),
    .sticky_invalid(n_sticky_invalid), .flag_clear(flag_clear), .special_cnt(n_special_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pairs in flight (oldest first) with edges seen since accept.
  typedef struct {logic [31:0] a, b; int age;} ent_t;
  ent_t q[$];
  int   m_cnt    = 0;
  bit   m_sticky = 0;
  bit   last_ixf, last_blocked;

  typedef struct {logic [31:0] a, b; logic [6:0] fl; logic zero_noftz;} vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int fexp(input logic [31:0] x);
    return int'(x >> 23) & 255;
  endfunction

  function automatic int fsig(input logic [31:0] x);
    return int'(x & 32'h007f_ffff);
  endfunction

  // {zero, aisnan, bisnan, infinity, asnan_sig, bsnan_sig, specialcase}
  function automatic logic [6:0] ref_flags(input logic [31:0] x, input logic [31:0] y,
                                           input bit ftz);
    bit zx, zy, ix, iy, nx, ny, sx, sy, z, inf;
    zx  = fexp(x) == 0 && (fsig(x) == 0 || ftz);
    zy  = fexp(y) == 0 && (fsig(y) == 0 || ftz);
    ix  = fexp(x) == 255 && fsig(x) == 0;
    iy  = fexp(y) == 255 && fsig(y) == 0;
    nx  = fexp(x) == 255 && fsig(x) != 0;
    ny  = fexp(y) == 255 && fsig(y) != 0;
    sx  = nx && fsig(x) < 32'h0040_0000;
    sy  = ny && fsig(y) < 32'h0040_0000;
    z   = zx || zy;
    inf = ix || iy;
    return {z, nx, ny, inf, sx, sy, z || nx || ny || inf};
  endfunction

  function automatic logic [31:0] gen();
    logic s;
    s = 1'($urandom);
    case ($urandom % 7)
      0:       return {s, 8'h00, 23'h0};
      1:       return {s, 8'h00, 23'($urandom_range(1, 32'h7f_ffff))};
      2:       return {s, 8'hff, 23'h0};
      3:       return {s, 8'hff, 1'b1, 22'($urandom)};
      4:       return {s, 8'hff, 1'b0, 22'($urandom_range(1, 32'h3f_ffff))};
      default: return $urandom;
    endcase
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cyc();
    bit         exp_ir, exp_ov, ixf, oxf, inc, inv;
    logic [6:0] ef, efn;
    ent_t       e;
    #1;
    exp_ir = (q.size() < 2) || out_ready;
    exp_ov = (q.size() >= 2) || (q.size() == 1 && q[0].age >= 1);
    ixf    = in_valid && exp_ir && !reset;
    oxf    = exp_ov && out_ready && !reset;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (out_valid && q.size() > 0) begin
      ef  = ref_flags(q[0].a, q[0].b, 1);
      efn = ref_flags(q[0].a, q[0].b, 0);
      chk("a_out", a_out, q[0].a);
      chk("b_out", b_out, q[0].b);
      chk("flags", {zero, aisnan, bisnan, infinity, asnan_sig, bsnan_sig, specialcase}, ef);
      chk("zero_noftz", n_zero, efn[6]);
    end
    chk("special_cnt", special_cnt, m_cnt);
    chk("sticky_invalid", sticky_invalid, m_sticky);
    last_ixf     = ixf;
    last_blocked = in_valid && !exp_ir;
    @(negedge clk);
    if (reset) begin
      q.delete();
      m_cnt    = 0;
      m_sticky = 0;
    end else begin
      inc = 0;
      inv = 0;
      if (oxf) begin
        e   = q.pop_front();
        ef  = ref_flags(e.a, e.b, 1);
        inc = ef[0];
        inv = (ef[6] && ef[3]) || ef[2] || ef[1];
      end
      m_sticky = (m_sticky && !flag_clear) || inv;
      if (flag_clear) m_cnt = inc ? 1 : 0;
      else if (inc && m_cnt < 15) m_cnt = m_cnt + 1;
      foreach (q[i]) q[i].age++;
      if (ixf) q.push_back('{a: a, b: b, age: 0});
    end
  endtask

  initial begin
    bit saw_block, acc;
    int stall, w;

    vt[0] = '{32'h3f80_0000, 32'h4000_0000, 7'b0000000, 1'b0};
    vt[1] = '{32'h7f80_0000, 32'h0000_0000, 7'b1001001, 1'b1};
    vt[2] = '{32'h7fc0_0001, 32'h7f80_0001, 7'b0110011, 1'b0};
    vt[3] = '{32'h0000_0001, 32'h3f80_0000, 7'b1000001, 1'b0};
    vt[4] = '{32'hff80_0000, 32'h3f80_0000, 7'b0001001, 1'b0};
    vt[5] = '{32'h8000_0000, 32'h7fbf_ffff, 7'b1010011, 1'b1};

    reset = 1; in_valid = 0; out_ready = 0; flag_clear = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_flags", {zero, aisnan, bisnan, infinity, asnan_sig, bsnan_sig, specialcase}, 0);
    chk("rst_cnt", special_cnt, 0);
    chk("rst_sticky", sticky_invalid, 0);
    reset = 0;

    // Directed table: one pair at a time, latency and flags checked explicitly.
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      a = vt[i].a; b = vt[i].b; in_valid = 1;
      cyc();
      chk("tbl_accept", last_ixf, 1);
      in_valid = 0;
      w = 0;
      while (w < 6 && !out_valid) begin
        cyc();
        w++;
      end
      chk("tbl_latency", w, 1);
      chk("tbl_flags", {zero, aisnan, bisnan, infinity, asnan_sig, bsnan_sig, specialcase},
          vt[i].fl);
      chk("tbl_zero_noftz", n_zero, vt[i].zero_noftz);
      cyc();
    end
    cyc();
    chk("tbl_cnt", special_cnt, 5);
    chk("tbl_sticky", sticky_invalid, 1);

    // Backpressure: four pairs with the sink stalled until the input blocks 3 cycles.
    out_ready = 0; saw_block = 0; stall = 0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; in_valid = 1; acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        cyc();
        acc = last_ixf;
        if (last_blocked) begin
          saw_block = 1;
          stall++;
          if (stall >= 3) out_ready = 1;
        end
      end
      chk("bp_accept", acc, 1);
    end
    in_valid = 0;
    repeat (6) cyc();
    chk("bp_in_ready_dropped", saw_block, 1);
    chk("bp_drained", q.size(), 0);

    // Clear, then saturate the 4-bit counter with 16 special results.
    flag_clear = 1; cyc(); flag_clear = 0;
    chk("clr_cnt", special_cnt, 0);
    chk("clr_sticky", sticky_invalid, 0);
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = 32'h0;
      cyc();
    end
    in_valid = 0;
    repeat (4) cyc();
    chk("sat_cnt", special_cnt, 15);

    // Clear concurrent with a special, invalid output transfer.
    a = 32'h7f80_0000; b = 32'h0; in_valid = 1;
    cyc();
    in_valid = 0;
    for (int t = 0; t < 6 && !out_valid; t++) cyc();
    flag_clear = 1; cyc(); flag_clear = 0;
    chk("clr_inc_cnt", special_cnt, 1);
    chk("clr_set_sticky", sticky_invalid, 1);
    flag_clear = 1; cyc(); flag_clear = 0;
    chk("clr_only_cnt", special_cnt, 0);
    chk("clr_only_sticky", sticky_invalid, 0);

    // Reset in the middle of a stalled stream.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a = gen(); b = 32'h7f80_0001;
      cyc();
    end
    reset = 1; in_valid = 0; out_ready = 1;
    cyc();
    reset = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cnt", special_cnt, 0);
    chk("midrst_sticky", sticky_invalid, 0);
    a = 32'h4040_0000; b = 32'h3f80_0000; in_valid = 1;
    cyc();
    chk("midrst_first_accept", last_ixf, 1);
    in_valid = 0;

    // Randomized traffic; operands held while an offer is blocked.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && last_blocked)) begin
        in_valid = ($urandom % 4) != 0;
        a = gen(); b = gen();
      end
      out_ready  = ($urandom % 3) != 0;
      flag_clear = ($urandom % 16) == 0;
      reset      = ($urandom % 250) == 0;
      cyc();
    end
    reset = 0; flag_clear = 0; in_valid = 0; out_ready = 1;
    repeat (5) cyc();
    chk("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
